phy_rx_deserializer: RTL and testbench

Serial receive stage downstream of the PHY serializer: consumes the 1-bit line stream at clk_32f, one bit per cycle, MSB first.
Acquires byte alignment on the comma/idle symbol 0xBC and locks after LOCK_COUNT consecutive aligned commas.
Once locked, rebuilds 32-bit words and presents them to the parallel side as Data_out/valid_out.
Idle words (0xBCBCBCBC) are suppressed, so the output matches the Data_in/valid_in pair that fed the transmitter.

---
 rtl/phy_pkg.sv | 17 +
 rtl/phy_rx_deserializer_if.sv | 34 +++
 rtl/phy_rx_comma_align.sv | 87 ++++++++
 rtl/phy_rx_deserializer.sv | 78 +++++++
 tb/tb_phy_rx_deserializer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/phy_pkg.sv
// Shared definitions for the PHY serial link: the comma/idle symbol, the idle
// word, the default lock threshold and the 2-bit link state encoding that the
// transmit and receive sides have in common.
package phy_pkg;

    localparam logic [7:0]  COMMA          = 8'hBC;
    localparam int unsigned WORD_W         = 32;
    localparam logic [31:0] IDLE_WORD      = {4{COMMA}};
    localparam int unsigned LOCK_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } phy_state_t;

endpackage

// File: rtl/phy_rx_deserializer_if.sv
// Serial-in / parallel-out bundle of the receive deserializer.
// Handshake: there is no back-pressure. valid_out is a one-cycle pulse; the
// consumer must take Data_out in the cycle valid_out is high. Data_out holds
// its last value otherwise. data_in is sampled on every rising clk_32f edge.
// state is a debug view of the alignment FSM.
interface phy_rx_deserializer_if #(
    parameter int unsigned WIDTH = 32
) ();
    import phy_pkg::*;

    logic             data_in;
    logic [WIDTH-1:0] Data_out;
    logic             valid_out;
    logic             active;
    phy_state_t       state;

    // Line side / bench drives the serial bit and observes the parallel side
    modport master (
        output data_in,
        input  Data_out,
        input  valid_out,
        input  active,
        input  state
    );

    // Deserializer consumes the serial bit and produces the parallel side
    modport slave (
        input  data_in,
        output Data_out,
        output valid_out,
        output active,
        output state
    );
endinterface

// File: rtl/phy_rx_comma_align.sv
// Comma aligner: slides an 8-bit window over the serial stream, locks onto
// the comma byte grid and declares lock after LOCK_COUNT consecutive commas
// on that grid. Once locked it stays locked until reset.
module phy_rx_comma_align
    import phy_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in_i,
    output logic       lock_o,
    output logic       word_start_o,
    output phy_state_t state_o
);

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT);

    logic [7:0] byte_sr_q;
    logic [7:0] nb;
    logic [2:0] bit_cnt_q;
    logic [3:0] comma_cnt_q;
    phy_state_t state_q;
    logic       lock_q;
    logic       word_start_q;

    // Window including the bit being sampled this edge
    assign nb = {byte_sr_q[6:0], data_in_i};

    // Alignment FSM: free-running window shift, comma search and grid check
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            byte_sr_q    <= '0;
            bit_cnt_q    <= '0;
            comma_cnt_q  <= '0;
            state_q      <= ST_SEARCH;
            lock_q       <= 1'b0;
            word_start_q <= 1'b0;
        end else begin
            byte_sr_q    <= nb;
            word_start_q <= 1'b0;
            case (state_q)
                ST_SEARCH: begin
                    if (nb == COMMA) begin
                        bit_cnt_q   <= '0;
                        comma_cnt_q <= 4'd1;
                        if (LOCK_COUNT == 1) begin
                            state_q      <= ST_ACTIVE;
                            lock_q       <= 1'b1;
                            word_start_q <= 1'b1;
                        end else begin
                            state_q <= ST_ALIGN;
                        end
                    end
                end
                ST_ALIGN: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (nb == COMMA) begin
                            comma_cnt_q <= comma_cnt_q + 4'd1;
                            if (comma_cnt_q + 4'd1 == LOCK_LAST) begin
                                state_q      <= ST_ACTIVE;
                                lock_q       <= 1'b1;
                                word_start_q <= 1'b1;
                            end
                        end else begin
                            // Grid broken: restart the search on the next bit
                            state_q     <= ST_SEARCH;
                            comma_cnt_q <= '0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // No loss-of-lock detection; only reset leaves this state
                end
                default: begin
                    state_q <= ST_SEARCH;
                end
            endcase
        end
    end

    assign lock_o       = lock_q;
    assign word_start_o = word_start_q;
    assign state_o      = state_q;

endmodule

// File: rtl/phy_rx_deserializer.sv
// Receive deserializer top: after the aligner locks, gathers WIDTH serial
// bits MSB first into a word and presents every non-idle word as a one-cycle
// valid_out pulse. Idle words are dropped so the parallel side reproduces the
// transmitter's Data_in/valid_in stream.
module phy_rx_deserializer
    import phy_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int unsigned WIDTH      = WORD_W
) (
    input logic                  clk_32f,
    input logic                  reset,
    phy_rx_deserializer_if.slave bus
);

    localparam int unsigned    CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] IDLE = {(WIDTH / 8){COMMA}};

    logic             lock;
    logic             word_start;
    phy_state_t       align_state;

    logic [WIDTH-1:0] word_sr_q;
    logic [WIDTH-1:0] w;
    logic [CNT_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] word_cnt_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    phy_rx_comma_align #(
        .LOCK_COUNT (LOCK_COUNT)
    ) u_align (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .data_in_i    (bus.data_in),
        .lock_o       (lock),
        .word_start_o (word_start),
        .state_o      (align_state)
    );

    // Word as it stands including the bit sampled this edge
    assign w = {word_sr_q[WIDTH-2:0], bus.data_in};

    // Bit position within the word; the first locked cycle carries the word MSB
    always_comb begin
        word_cnt_d = word_cnt_q + 1'b1;
        if (word_start) begin
            word_cnt_d = CNT_W'(1);
        end
    end

    // Word assembly and output registers, idle words suppressed
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            word_sr_q  <= '0;
            word_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (lock) begin
                word_sr_q  <= w;
                word_cnt_q <= word_cnt_d;
                if (word_cnt_q == LAST && w != IDLE) begin
                    data_q  <= w;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.Data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = lock;
    assign bus.state     = align_state;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// Bench for phy_rx_deserializer: builds serial bit streams, derives the
// expected lock instant and delivered words from the stream with a plain
// window-scanning model, and lets a negedge monitor compare the DUT output.
module tb_phy_rx_deserializer;
    import phy_pkg::*;

    localparam int LC = 4;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    phy_rx_deserializer_if #(.WIDTH(32)) bus ();

    phy_rx_deserializer #(
        .LOCK_COUNT (LC),
        .WIDTH      (32)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    // Clock and cycle counter; rst_seen is the reset value the last edge sampled
    always #5 clk_32f = ~clk_32f;

    int   cyc = 0;
    logic rst_seen = 1'b0;
    always @(posedge clk_32f) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    // Scoreboard state
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          exp_act_q[$];
    logic [31:0] exp_data    = '0;
    logic        prev_active = 1'b0;
    bit          bits[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] win(int k);
        logic [7:0] v = '0;
        for (int i = k - 7; i <= k; i++) begin
            v = {v[6:0], (i >= 0) ? logic'(bits[i]) : 1'b0};
        end
        return v;
    endfunction

    function automatic logic [31:0] word_at(int s);
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v = {v[30:0], logic'(bits[s + i])};
        return v;
    endfunction

    // Scans the stream from a clean receiver: first comma anywhere, then LC-1
    // further commas on the same 8-bit grid; a broken grid resumes the scan
    // just after the offending byte. After lock, 32-bit words follow.
    task automatic model(input int c0, output int lock_idx);
        int n = bits.size();
        int k = 0;
        int j;
        int cnt;
        int s;
        logic [31:0] wv;
        lock_idx = -1;
        while (k < n && lock_idx < 0) begin
            if (win(k) == COMMA) begin
                j   = k;
                cnt = 1;
                while (cnt < LC && j + 8 < n && win(j + 8) == COMMA) begin
                    j += 8;
                    cnt++;
                end
                if (cnt == LC) lock_idx = j;
                else k = j + 9;
            end else begin
                k++;
            end
        end
        if (lock_idx >= 0) begin
            exp_act_q.push_back(c0 + lock_idx + 1);
            s = lock_idx + 1;
            while (s + 31 < n) begin
                wv = word_at(s);
                if (wv != IDLE_WORD) begin
                    exp_q.push_back(wv);
                    exp_cyc_q.push_back(c0 + s + 32);
                end
                s += 32;
            end
        end
    endtask

    // ---------------- stream builders ----------------
    task automatic push_bits(input logic [31:0] v, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) bits.push_back(v[i]);
    endtask

    task automatic push_commas(input int n);
        for (int i = 0; i < n; i++) push_bits({24'h0, COMMA}, 8);
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left just after a rising edge
    task automatic do_reset(input int n);
        reset = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        exp_act_q.delete();
        repeat (n) begin
            bus.data_in = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
        end
        reset = 1'b0;
    endtask

    // Drives the built stream right after reset, then checks that everything
    // expected has been delivered and the lock level matches the model
    task automatic run_segment();
        int c0 = cyc;
        int lock_idx;
        model(c0, lock_idx);
        foreach (bits[k]) begin
            bus.data_in = bits[k];
            @(posedge clk_32f);
            #1;
        end
        @(negedge clk_32f);
        #1;
        check("words_pending", 32'(exp_q.size()), 32'd0);
        check("lock_pending", 32'(exp_act_q.size()), 32'd0);
        check("active_level", 32'(bus.active), 32'(lock_idx >= 0));
        bits.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk_32f) begin
        if (rst_seen) begin
            check("rst_data", bus.Data_out, 32'h0);
            check("rst_valid", 32'(bus.valid_out), 32'h0);
            check("rst_active", 32'(bus.active), 32'h0);
            check("rst_state", 32'(bus.state), 32'(ST_SEARCH));
            exp_data    = '0;
            prev_active = 1'b0;
        end else begin
            if (bus.active && !prev_active) begin
                if (exp_act_q.size() == 0) check("unexpected_lock", 32'h1, 32'h0);
                else check("lock_cycle", 32'(cyc), 32'(exp_act_q.pop_front()));
            end
            if (!bus.active && prev_active) check("lock_lost", 32'h0, 32'h1);
            prev_active = bus.active;
            if (bus.valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", bus.Data_out, 32'hxxxxxxxx);
                end else begin
                    exp_data = exp_q.pop_front();
                    check("word_data", bus.Data_out, exp_data);
                    check("word_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end else begin
                check("data_hold", bus.Data_out, exp_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.data_in = 1'b0;
        @(posedge clk_32f);
        #1;

        // 1: reset with random line data, receiver idle afterwards
        do_reset(3);
        push_bits(32'h0, 8);
        run_segment();
        check("search_after_reset", 32'(bus.state), 32'(ST_SEARCH));

        // 2: basic lock and one word followed by idle
        do_reset(2);
        push_commas(4);
        push_bits(32'hDEADBEEF, 32);
        push_bits(IDLE_WORD, 32);
        run_segment();

        // 3: broken comma run, lock only on the second full run
        do_reset(2);
        push_commas(3);
        push_bits(32'h0, 8);
        push_commas(4);
        push_bits(32'h0BADF00D, 32);
        run_segment();

        // 4: misaligned prefix before the commas
        do_reset(2);
        push_bits($urandom, 3);
        push_commas(4);
        push_bits(32'h12345678, 32);
        run_segment();

        // 5: idle suppression and commas embedded in data
        do_reset(2);
        push_commas(4);
        push_bits(32'hCAFEF00D, 32);
        push_bits(IDLE_WORD, 32);
        push_bits(32'h00BC00BC, 32);
        run_segment();

        // 6: reset at bit 17 of a word, then full re-acquisition
        do_reset(2);
        push_commas(4);
        push_bits(32'hA5A55A5A, 32);
        push_bits(32'h13579BDF, 17);
        run_segment();
        do_reset(1);
        push_commas(3);
        push_bits(32'h87654321, 32);
        run_segment();
        do_reset(1);
        push_commas(4);
        push_bits(32'h2468ACE0, 32);
        run_segment();

        // Randomised streams: prefix, comma runs with optional glitch, mixed words
        for (int t = 0; t < 30; t++) begin
            int ncom;
            int nw;
            do_reset(int'($urandom_range(1, 3)));
            push_bits($urandom, int'($urandom_range(0, 12)));
            ncom = int'($urandom_range(2, 6));
            push_commas(ncom);
            if ($urandom_range(0, 3) == 0) begin
                push_bits(32'($urandom_range(0, 255)), 8);
                push_commas(int'($urandom_range(3, 5)));
            end
            nw = int'($urandom_range(1, 5));
            for (int i = 0; i < nw; i++) begin
                case ($urandom_range(0, 3))
                    0:       push_bits(IDLE_WORD, 32);
                    1:       push_bits({COMMA, 8'($urandom), COMMA, 8'($urandom)}, 32);
                    default: push_bits($urandom, 32);
                endcase
            end
            if ($urandom_range(0, 2) == 0) push_bits($urandom, int'($urandom_range(1, 31)));
            run_segment();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the run is bounded by the stimulus, this only guards a stall
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
